mem_net_tag_arbiter: RTL

Shares one memory-network request port among `p_num_arb` requesters and routes the returning responses back to the requester that issued them. It sits between the per-unit memory clients and the single network request/response channel. Grant selection is round-robin, a grant is locked while the network back-pressures, and each requester is limited to a bounded number of outstanding requests. The requester index is carried in the top bits of the opaque field.

---
 rtl/mem_net_arb_pkg.sv | 18 +
 rtl/mem_net_credit_ctr.sv | 36 +++
 rtl/mem_net_tag_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mem_net_arb_pkg.sv
// Shared types and constants for the memory-network tag arbiter.
// Message base widths, ID-width helper and lock-state encoding.
package mem_net_arb_pkg;

    localparam int REQ_BASE_BITS  = 71;
    localparam int RESP_BASE_BITS = 39;
    localparam int CNT_BITS       = 4;

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_net_credit_ctr.sv
// Per-requester outstanding-request counter, saturating at p_max_out.
// Simultaneous inc/dec leaves the count unchanged.
module mem_net_credit_ctr
    import mem_net_arb_pkg::*;
#(
    parameter int p_max_out = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic at_max
);

    localparam logic [CNT_BITS-1:0] MAX = CNT_BITS'(p_max_out);

    logic [CNT_BITS-1:0] cnt;
    logic                up;
    logic                dn;

    assign up     = inc && (cnt != MAX);
    assign dn     = dec && (cnt != '0);
    assign at_max = (cnt == MAX);

    // Count issued requests up, returned responses down.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (up && !dn) begin
            cnt <= cnt + 1'b1;
        end else if (dn && !up) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/mem_net_tag_arbiter.sv
// Round-robin arbiter sharing one memory-network port, tagging requests
// with the requester ID. Optional credit limit: MEM_NET_ARB_CREDIT_EN.
module mem_net_tag_arbiter
    import mem_net_arb_pkg::*;
#(
    parameter int p_num_arb   = 3,
    parameter int p_opaq_bits = 8,
    parameter int p_max_out   = 4,
    parameter int p_req_bits  = REQ_BASE_BITS + p_opaq_bits,
    parameter int p_resp_bits = RESP_BASE_BITS + p_opaq_bits
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [p_num_arb-1:0]                  req_val,
    output logic [p_num_arb-1:0]                  req_rdy,
    input  logic [p_num_arb-1:0][p_req_bits-1:0]  req_msg,
    output logic                                  net_req_val,
    input  logic                                  net_req_rdy,
    output logic [p_req_bits-1:0]                 net_req_msg,
    input  logic                                  net_resp_val,
    output logic                                  net_resp_rdy,
    input  logic [p_resp_bits-1:0]                net_resp_msg,
    output logic [p_num_arb-1:0]                  resp_val,
    input  logic [p_num_arb-1:0]                  resp_rdy,
    output logic [p_num_arb-1:0][p_resp_bits-1:0] resp_msg,
    output logic                                  err_bad_id
);

    localparam int IDW = id_width(p_num_arb);
    localparam int IDH = p_opaq_bits - 1;
    localparam logic [IDW:0] NUM_ARB = (IDW+1)'(p_num_arb);
    localparam logic [IDW-1:0] LAST = IDW'(p_num_arb - 1);

    lock_state_e          state;
    logic [IDW-1:0]       ptr;
    logic [IDW-1:0]       lk_idx;
    logic [IDW-1:0]       win;
    logic [IDW-1:0]       grant;
    logic [IDW-1:0]       ptr_nxt;
    logic [IDW-1:0]       rsp_id;
    logic [p_num_arb-1:0] elig;
    logic [p_num_arb-1:0] at_max;
    logic                 any_elig;
    logic                 req_go;
    logic                 req_fire;
    logic                 rsp_ok;
    logic [p_resp_bits-1:0] rsp_clr;

    assign elig = req_val & ~at_max;

    // First eligible requester at or after ptr, with wrap-around.
    always_comb begin
        int j;
        win      = '0;
        any_elig = 1'b0;
        j        = 0;
        for (int k = 0; k < p_num_arb; k++) begin
            j = int'(ptr) + k;
            if (j >= p_num_arb) begin
                j = j - p_num_arb;
            end
            if (!any_elig && elig[j]) begin
                any_elig = 1'b1;
                win      = IDW'(j);
            end
        end
    end

    assign grant = (state == LOCKED) ? lk_idx : win;
    assign req_go = rst && ((state == LOCKED) ? req_val[grant] : any_elig);
    assign net_req_val = req_go;
    assign req_fire = req_go && net_req_rdy;
    assign ptr_nxt = (grant == LAST) ? '0 : grant + 1'b1;

    // Ready goes only to the granted requester; tag its message.
    always_comb begin
        req_rdy        = '0;
        req_rdy[grant] = req_fire;
        net_req_msg    = req_msg[grant];
        net_req_msg[IDH -: IDW] = grant;
    end

    // Round-robin pointer and grant lock while the network stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= UNLOCKED;
            lk_idx <= '0;
            ptr    <= '0;
        end else begin
            if (req_fire) begin
                ptr <= ptr_nxt;
            end
            case (state)
                UNLOCKED: begin
                    if (req_go && !net_req_rdy) begin
                        state  <= LOCKED;
                        lk_idx <= win;
                    end
                end
                LOCKED: begin
                    if (req_fire) begin
                        state <= UNLOCKED;
                    end
                end
                default: state <= UNLOCKED;
            endcase
        end
    end

    assign rsp_id = net_resp_msg[IDH -: IDW];
    assign rsp_ok = {1'b0, rsp_id} < NUM_ARB;

    // Route the response by ID; illegal IDs are swallowed.
    always_comb begin
        resp_val = '0;
        if (rsp_ok) begin
            resp_val[rsp_id] = rst && net_resp_val;
        end
        net_resp_rdy = rst && (rsp_ok ? resp_rdy[rsp_id] : 1'b1);
        rsp_clr = net_resp_msg;
        rsp_clr[IDH -: IDW] = '0;
        for (int i = 0; i < p_num_arb; i++) begin
            resp_msg[i] = rsp_clr;
        end
    end

    // Sticky flag for responses carrying an out-of-range ID.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_bad_id <= 1'b0;
        end else if (net_resp_val && !rsp_ok) begin
            err_bad_id <= 1'b1;
        end
    end

`ifdef MEM_NET_ARB_CREDIT_EN
    logic                 rsp_fire;
    logic [p_num_arb-1:0] inc;
    logic [p_num_arb-1:0] dec;

    assign rsp_fire = net_resp_val && net_resp_rdy && rsp_ok;

    for (genvar i = 0; i < p_num_arb; i++) begin : g_ctr
        assign inc[i] = req_fire && (grant == IDW'(i));
        assign dec[i] = rsp_fire && (rsp_id == IDW'(i));

        mem_net_credit_ctr #(
            .p_max_out(p_max_out)
        ) u_ctr (
            .clk   (clk),
            .rst   (rst),
            .inc   (inc[i]),
            .dec   (dec[i]),
            .at_max(at_max[i])
        );
    end
`else
    // No credit tracking; only a degenerate zero limit would block.
    assign at_max = {p_num_arb{p_max_out == 0}};
`endif

endmodule
